// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issuing pipeline and the HI/LO multiply/divide unit.
// start_in is a one-cycle request; it is taken on a rising edge only when stall_out is low.
interface muldiv_unit_if;
    logic        start_in;
    logic [5:0]  funct_in;
    logic [31:0] rs_in;
    logic [31:0] rt_in;
    logic        cancel_in;
    logic        busy_out;
    logic        stall_out;
    logic        done_out;
    logic [31:0] result_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start_in, funct_in, rs_in, rt_in, cancel_in,
        input  busy_out, stall_out, done_out, result_out, hi_out, lo_out
    );

    modport slave (
        input  start_in, funct_in, rs_in, rt_in, cancel_in,
        output busy_out, stall_out, done_out, result_out, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations plus one sign-fix cycle.
module muldiv_unit (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_unit_if.slave      bus,
    output logic [2:0]        state_dbg
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state, state_nxt;
    logic        busy, done;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic [31:0] rs_raw;
    logic        neg_q, neg_r, dz, op_div;
    logic [4:0]  cnt;
    logic [31:0] hi, lo;

    logic is_mul, is_div, is_mt, is_mf, known, accept;
    assign is_mul = (bus.funct_in == F_MULT) || (bus.funct_in == F_MULTU);
    assign is_div = (bus.funct_in == F_DIV)  || (bus.funct_in == F_DIVU);
    assign is_mt  = (bus.funct_in == F_MTHI) || (bus.funct_in == F_MTLO);
    assign is_mf  = (bus.funct_in == F_MFHI) || (bus.funct_in == F_MFLO);
    assign known  = is_mul || is_div || is_mt || is_mf;
    assign accept = bus.start_in && known && !busy && !bus.cancel_in;

    // Even funct codes (MULT, DIV) are the signed variants.
    logic        sgn_op, sa, sb;
    logic [31:0] rs_mag, rt_mag;
    assign sgn_op = !bus.funct_in[0];
    assign sa     = sgn_op && bus.rs_in[31];
    assign sb     = sgn_op && bus.rt_in[31];
    assign rs_mag = sa ? -bus.rs_in : bus.rs_in;
    assign rt_mag = sb ? -bus.rt_in : bus.rt_in;

    // acc = {partial product, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [32:0] div_top;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    assign div_top  = acc[63:31];
    assign div_ge   = div_top >= {1'b0, opnd};
    assign div_diff = div_top[31:0] - opnd;
    assign div_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {div_top[31:0], acc[30:0], 1'b0};

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = dz ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
    assign rem_fix  = dz ? rs_raw : (neg_r ? -acc[63:32] : acc[63:32]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept && is_mul)      state_nxt = S_MUL;
                else if (accept && is_div) state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (cnt == 5'd31) state_nxt = S_FIX;
            S_FIX:        state_nxt = S_DONE;
            default:      state_nxt = S_IDLE;
        endcase
        if (bus.cancel_in) state_nxt = S_IDLE;
    end

    always_comb begin
        busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opnd   <= '0;
            rs_raw <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            op_div <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (!bus.cancel_in) begin
            if (accept) begin
                if (bus.funct_in == F_MTHI) hi <= bus.rs_in;
                if (bus.funct_in == F_MTLO) lo <= bus.rs_in;
                if (is_mul || is_div) begin
                    acc    <= is_div ? {32'd0, rs_mag} : {32'd0, rt_mag};
                    opnd   <= is_div ? rt_mag : rs_mag;
                    rs_raw <= bus.rs_in;
                    neg_q  <= sa ^ sb;
                    neg_r  <= sa;
                    dz     <= is_div && (bus.rt_in == 32'd0);
                    op_div <= is_div;
                    cnt    <= '0;
                end
            end else if (state == S_MUL) begin
                acc <= mul_next;
                cnt <= cnt + 5'd1;
            end else if (state == S_DIV) begin
                acc <= div_next;
                cnt <= cnt + 5'd1;
            end else if (state == S_FIX) begin
                if (op_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[63:32];
                    lo <= prod_fix[31:0];
                end
            end
        end
    end

    assign bus.busy_out   = busy;
    assign bus.done_out   = done;
    assign bus.stall_out  = bus.start_in && busy && known;
    assign bus.hi_out     = hi;
    assign bus.lo_out     = lo;
    assign bus.result_out = (bus.funct_in == F_MFHI) ? hi :
                            (bus.funct_in == F_MFLO) ? lo : 32'd0;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized operations
// compared against an arithmetic model of HI/LO.
module tb_muldiv_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // {HI, LO} from the instruction-set definition of each operation.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (f)
            F_MULT:  res = sa * sb;
            F_MULTU: res = {32'd0, a} * {32'd0, b};
            F_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.funct_in = f;
        bus.rs_in    = a;
        bus.rt_in    = b;
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.rs_in    = $urandom;
        bus.rt_in    = $urandom;
    endtask

    task automatic wait_done(output int busy_cyc, output bit seen);
        busy_cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done_out) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy_out) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int bc;
        bit seen;
        exp = ref_op(f, a, b);
        issue(f, a, b);
        wait_done(bc, seen);
        check_eq({tag, "_busy_cycles"}, 64'(bc), 64'd33);
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_eq({tag, "_hi"}, 64'(bus.hi_out), 64'(exp[63:32]));
        check_eq({tag, "_lo"}, 64'(bus.lo_out), 64'(exp[31:0]));
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 64'(bus.done_out), 64'd0);
    endtask

    initial begin
        int bc, gap, n_done;
        bit seen;
        logic [63:0] exp, exp2;
        bus.start_in  = 1'b0;
        bus.funct_in  = F_MFHI;
        bus.rs_in     = '0;
        bus.rt_in     = '0;
        bus.cancel_in = 1'b0;

        // Reset state, including combinational outputs during reset
        #1;
        check_eq("rst_busy", 64'(bus.busy_out), 64'd0);
        check_eq("rst_done", 64'(bus.done_out), 64'd0);
        check_eq("rst_hi", 64'(bus.hi_out), 64'd0);
        check_eq("rst_lo", 64'(bus.lo_out), 64'd0);
        bus.start_in = 1'b1;
        #1;
        check_eq("rst_result_mfhi", 64'(bus.result_out), 64'd0);
        check_eq("rst_stall", 64'(bus.stall_out), 64'd0);
        bus.start_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("mult_neg2x3", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        check_eq("mult_neg2x3_hi_const", 64'(bus.hi_out), 64'hFFFF_FFFF);
        check_eq("mult_neg2x3_lo_const", 64'(bus.lo_out), 64'hFFFF_FFFA);

        // MULTU followed by a MFLO held during busy
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.funct_in = F_MULTU;
        bus.rs_in    = 32'hFFFF_FFFF;
        bus.rt_in    = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.funct_in = F_MFLO;
        bus.rs_in    = $urandom;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.done_out) begin
                seen = 1'b1;
                break;
            end
            check_eq("mflo_stall_busy", 64'(bus.stall_out), 64'd1);
            @(negedge clk);
        end
        check_eq("multu_done_seen", 64'(seen), 64'd1);
        check_eq("mflo_stall_done", 64'(bus.stall_out), 64'd0);
        check_eq("mflo_result", 64'(bus.result_out), 64'h0000_0001);
        check_eq("multu_hi", 64'(bus.hi_out), 64'hFFFF_FFFE);
        bus.funct_in = F_MFHI;
        #1;
        check_eq("mfhi_result", 64'(bus.result_out), 64'hFFFF_FFFE);
        bus.start_in = 1'b0;
        model_hi = 32'hFFFF_FFFE;
        model_lo = 32'h0000_0001;

        run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check_eq("div_neg7_2_lo_const", 64'(bus.lo_out), 64'hFFFF_FFFD);
        check_eq("div_neg7_2_hi_const", 64'(bus.hi_out), 64'hFFFF_FFFF);
        run_op("divu_by0", F_DIVU, 32'h0000_0007, 32'h0);
        check_eq("divu_by0_lo_const", 64'(bus.lo_out), 64'hFFFF_FFFF);
        check_eq("divu_by0_hi_const", 64'(bus.hi_out), 64'h0000_0007);
        run_op("div_neg_by0", F_DIV, 32'hFFFF_FF00, 32'h0);
        run_op("div_min_by_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_min_lo_const", 64'(bus.lo_out), 64'h8000_0000);
        check_eq("div_min_hi_const", 64'(bus.hi_out), 64'h0000_0000);

        // Unknown funct is ignored
        @(negedge clk);
        bus.start_in = 1'b1;
        bus.funct_in = 6'h20;
        bus.rs_in    = 32'hDEAD_BEEF;
        #1;
        check_eq("unk_stall", 64'(bus.stall_out), 64'd0);
        check_eq("unk_result", 64'(bus.result_out), 64'd0);
        @(negedge clk);
        bus.start_in = 1'b0;
        check_eq("unk_busy", 64'(bus.busy_out), 64'd0);
        check_eq("unk_hi", 64'(bus.hi_out), 64'(model_hi));
        check_eq("unk_lo", 64'(bus.lo_out), 64'(model_lo));

        // MTHI then a cancelled DIVU
        issue(F_MTHI, 32'h1234_5678, 32'h0);
        model_hi = 32'h1234_5678;
        check_eq("mthi_hi", 64'(bus.hi_out), 64'h1234_5678);
        check_eq("mthi_busy", 64'(bus.busy_out), 64'd0);
        check_eq("mthi_done", 64'(bus.done_out), 64'd0);
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        check_eq("cancel_pre_busy", 64'(bus.busy_out), 64'd1);
        bus.cancel_in = 1'b1;
        @(negedge clk);
        bus.cancel_in = 1'b0;
        check_eq("cancel_busy_drop", 64'(bus.busy_out), 64'd0);
        n_done = 0;
        repeat (40) begin
            if (bus.done_out) n_done++;
            @(negedge clk);
        end
        check_eq("cancel_no_done", 64'(n_done), 64'd0);
        check_eq("cancel_hi", 64'(bus.hi_out), 64'h1234_5678);
        check_eq("cancel_lo", 64'(bus.lo_out), 64'(model_lo));

        // New MULT accepted in the DONE cycle
        exp  = ref_op(F_MULT, 32'd12345, 32'hFFFF_FF85);
        exp2 = ref_op(F_MULT, 32'h8000_0000, 32'h7FFF_FFFF);
        issue(F_MULT, 32'd12345, 32'hFFFF_FF85);
        wait_done(bc, seen);
        check_eq("b2b_first_done", 64'(seen), 64'd1);
        check_eq("b2b_first_lo", 64'(bus.lo_out), 64'(exp[31:0]));
        bus.start_in = 1'b1;
        bus.funct_in = F_MULT;
        bus.rs_in    = 32'h8000_0000;
        bus.rt_in    = 32'h7FFF_FFFF;
        #1;
        check_eq("b2b_stall_in_done", 64'(bus.stall_out), 64'd0);
        gap = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            gap++;
            if (gap == 1) check_eq("b2b_busy_next", 64'(bus.busy_out), 64'd1);
            if (bus.done_out) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("b2b_gap", 64'(gap), 64'd34);
        check_eq("b2b_second_hi", 64'(bus.hi_out), 64'(exp2[63:32]));
        check_eq("b2b_second_lo", 64'(bus.lo_out), 64'(exp2[31:0]));
        model_hi = exp2[63:32];
        model_lo = exp2[31:0];

        // Randomized operations against the model
        for (int n = 0; n < 24; n++) begin
            int k;
            logic [31:0] a, b;
            logic [5:0] f;
            k = $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
            case (k)
                0: run_op("rnd_mult", F_MULT, a, b);
                1: run_op("rnd_multu", F_MULTU, a, b);
                2: run_op("rnd_div", F_DIV, a, b);
                3: run_op("rnd_divu", F_DIVU, a, b);
                4: begin
                    f = $urandom_range(0, 1) ? F_MTHI : F_MTLO;
                    issue(f, a, b);
                    if (f == F_MTHI) model_hi = a;
                    else             model_lo = a;
                    check_eq("rnd_mt_hi", 64'(bus.hi_out), 64'(model_hi));
                    check_eq("rnd_mt_lo", 64'(bus.lo_out), 64'(model_lo));
                end
                default: begin
                    @(negedge clk);
                    bus.funct_in = F_MFHI;
                    #1;
                    check_eq("rnd_mfhi", 64'(bus.result_out), 64'(model_hi));
                    bus.funct_in = F_MFLO;
                    #1;
                    check_eq("rnd_mflo", 64'(bus.result_out), 64'(model_lo));
                end
            endcase
        end

        // Asynchronous reset in the middle of a MULT
        issue(F_MTLO, 32'hABCD_1234, 32'h0);
        issue(F_MULT, 32'd7, 32'd9);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 64'(bus.busy_out), 64'd0);
        check_eq("arst_done", 64'(bus.done_out), 64'd0);
        check_eq("arst_hi", 64'(bus.hi_out), 64'd0);
        check_eq("arst_lo", 64'(bus.lo_out), 64'd0);
        bus.funct_in = F_MFLO;
        bus.start_in = 1'b1;
        #1;
        check_eq("arst_result", 64'(bus.result_out), 64'd0);
        check_eq("arst_stall", 64'(bus.stall_out), 64'd0);
        bus.start_in = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("arst_held_busy", 64'(bus.busy_out), 64'd0);
        // First request taken at the first edge after release
        exp = ref_op(F_MULTU, 32'd5, 32'd6);
        rst_n = 1'b1;
        bus.start_in = 1'b1;
        bus.funct_in = F_MULTU;
        bus.rs_in    = 32'd5;
        bus.rt_in    = 32'd6;
        @(negedge clk);
        bus.start_in = 1'b0;
        check_eq("post_rst_busy", 64'(bus.busy_out), 64'd1);
        wait_done(bc, seen);
        check_eq("post_rst_busy_cycles", 64'(bc), 64'd33);
        check_eq("post_rst_done", 64'(seen), 64'd1);
        check_eq("post_rst_lo", 64'(bus.lo_out), 64'(exp[31:0]));
        check_eq("post_rst_hi", 64'(bus.hi_out), 64'(exp[63:32]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 The port clk SHALL be an input, 1 bit wide: the clock, with all state changing on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: the asynchronous, active-low reset.
REQ-004 The port start_in SHALL be an input, 1 bit wide: an operation request, valid for one cycle.
REQ-005 The port funct_in SHALL be an input, 6 bits wide: the R-type funct code; 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x12 MFLO, 0x11 MTHI, 0x13 MTLO.
REQ-006 The port rs_in SHALL be an input, 32 bits wide: the multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The port rt_in SHALL be an input, 32 bits wide: the multiplier or divisor.
REQ-008 The port cancel_in SHALL be an input, 1 bit wide: a pipeline flush that aborts any in-flight operation.
REQ-009 The port busy_out SHALL be an output, 1 bit wide: high while an iterative operation is in flight.
REQ-010 The port stall_out SHALL be an output, 1 bit wide: combinational; the current request is not accepted.
REQ-011 The port done_out SHALL be an output, 1 bit wide: a one-cycle pulse marking the cycle in which HI/LO hold a new result.
REQ-012 The port result_out SHALL be an output, 32 bits wide: the MFHI/MFLO read data.
REQ-013 The ports hi_out and lo_out SHALL each be an output, 32 bits wide, driven directly from the architectural HI and LO registers.

Function
REQ-014 A request SHALL be accepted at a rising edge when start_in=1, stall_out=0 and funct_in is one of the eight listed codes; any other funct_in SHALL be ignored, with no state change and stall_out=0.
REQ-015 stall_out SHALL be 1 if and only if start_in=1, busy_out=1 and funct_in is any listed code.
REQ-016 The state machine SHALL have the states IDLE, MUL, DIV, FIX and DONE.
REQ-017 The state machine SHALL transition as follows:
- IDLE to MUL on an accepted MULT/MULTU; IDLE to DIV on an accepted DIV/DIVU.
- MUL or DIV to FIX after 32 iteration cycles.
- FIX to DONE unconditionally.
- DONE to IDLE, or directly to MUL/DIV if a new request is accepted in the DONE cycle.
REQ-018 busy_out SHALL be 1 in the MUL, DIV and FIX states and 0 in IDLE and DONE.
REQ-019 For a request accepted at edge E0, the iterations SHALL occur at E1..E32, and HI/LO SHALL be written at E33.
- busy_out is high for exactly 33 cycles.
- done_out is high for the single cycle following E33.
REQ-020 Operand capture SHALL work as follows:
- Operands are latched at acceptance; rs_in and rt_in are don't-care afterwards.
- Signed operations convert the operands to magnitudes and record the result sign(s).
REQ-021 Multiply SHALL use radix-2 shift-add over a 64-bit accumulator, and the FIX state SHALL negate the 64-bit product if the operand signs differ, writing {HI,LO} = product.
REQ-022 Divide SHALL use radix-2 restoring division, and the FIX state SHALL apply these sign rules:
- The quotient is negated if the operand signs differ, which truncates toward zero.
- The remainder is negated if the dividend is negative.
- LO = quotient; HI = remainder.
REQ-023 For a divisor of 0 (signed or unsigned), the operation SHALL still take 33 busy cycles and produce LO=0xFFFFFFFF and HI=the dividend as latched.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0x00000000.
REQ-025 MTHI and MTLO SHALL write rs_in into HI or LO respectively at the accepting edge, with no change to busy_out and no done_out pulse.
REQ-026 result_out SHALL be combinational:
- HI when funct_in=0x10.
- LO when funct_in=0x12.
- Otherwise 0.
- Valid only when stall_out=0.
REQ-027 cancel_in=1 at a rising edge SHALL take priority over everything else:
- The state returns to IDLE.
- HI and LO are unchanged.
- No done_out pulse occurs.
- Any request presented on that edge is dropped.
REQ-028 cancel_in while in IDLE or DONE SHALL have no effect other than dropping a same-edge request.
REQ-029 HI and LO SHALL change only at the FIX-to-DONE edge, on an MTHI/MTLO accept, or on reset.

Reset
REQ-030 While rst_n=0, the block SHALL be held in reset, regardless of clk:
- State = IDLE.
- busy_out=0, done_out=0.
- HI=0x00000000, LO=0x00000000.
- The internal accumulator, counter and operand registers are cleared.
REQ-031 stall_out and result_out SHALL follow their combinational definitions during reset, which gives result_out=0 for MFHI/MFLO.
REQ-032 Reset asserted mid-operation SHALL abort the operation, leaving HI/LO=0 and producing no done_out pulse.
REQ-033 The first request SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-034 The bench SHALL check signed multiply: MULT with rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy_out for 33 cycles, done_out one cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 The bench SHALL check unsigned multiply and back-to-back issue:
- MULTU with rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- A MFLO presented during busy -> stall_out=1 each cycle until done_out, then result_out=0x00000001 with stall_out=0.
REQ-036 The bench SHALL check signed divide and divide-by-zero:
- DIV with rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU with rs=0x00000007, rt=0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-037 The bench SHALL check cancel: MTHI with rs=0x12345678, then DIVU, then cancel_in at iteration 10 -> busy_out drops the next cycle, no done_out, HI=0x12345678 unchanged.
REQ-038 The bench SHALL check a request issued in the DONE cycle: a new MULT accepted in the done_out cycle -> busy_out=1 on the next cycle and a second done_out exactly 34 cycles after the first.
REQ-039 The bench SHALL check reset mid-operation: rst_n pulsed low during a MULT -> busy_out, done_out, HI and LO all 0 immediately, without waiting for a clk edge.
